// File: rtl/skid_register_pkg.sv
// Shared types for skid_register: occupancy state encoding and main-register load select.
package skid_register_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2,
    ST_RSVD  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SEL_HOLD = 2'd0,
    SEL_IN   = 2'd1,
    SEL_SKID = 2'd2,
    SEL_ZERO = 2'd3
  } main_sel_e;

  function automatic logic state_has_beat(input state_e st);
    return (st == ST_BUSY) || (st == ST_FULL);
  endfunction

endpackage

// File: rtl/skid_register.sv
// Two-entry ready/valid register slice: out_data/out_valid and in_ready all come straight from flops.
// Defining SKID_REGISTER_STATS_EN adds the saturating beat_count output.
module skid_register
  import skid_register_pkg::*;
#(
  parameter int N     = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [N-1:0]     in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [N-1:0]     out_data,
  output logic             out_valid,
  input  logic             out_ready
`ifdef SKID_REGISTER_STATS_EN
  ,
  output logic [CNT_W-1:0] beat_count
`endif
);

  state_e    r_state;
  state_e    w_state_nxt;
  main_sel_e w_main_sel;
  logic      w_skid_load;

  logic [N-1:0] r_main;
  logic [N-1:0] r_skid;
  logic [N-1:0] w_main_nxt;
  logic [N-1:0] w_skid_nxt;
  logic         r_out_valid;
  logic         r_in_ready;
  logic         w_out_valid_nxt;
  logic         w_in_ready_nxt;

  logic w_in_fire;
  logic w_out_fire;

  assign w_in_fire  = in_valid & r_in_ready;
  assign w_out_fire = r_out_valid & out_ready;

  assign out_data  = r_main;
  assign out_valid = r_out_valid;
  assign in_ready  = r_in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // In FULL in_ready is low, so only out_fire can move the state.
  always_comb begin
    w_state_nxt = r_state;
    w_main_sel  = SEL_HOLD;
    w_skid_load = 1'b0;
    if (clear) begin
      w_state_nxt = ST_EMPTY;
      w_main_sel  = SEL_ZERO;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            w_state_nxt = ST_BUSY;
            w_main_sel  = SEL_IN;
          end else begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_BUSY: begin
          if (w_in_fire && w_out_fire) begin
            w_state_nxt = ST_BUSY;
            w_main_sel  = SEL_IN;
          end else if (w_in_fire) begin
            w_state_nxt = ST_FULL;
            w_skid_load = 1'b1;
          end else if (w_out_fire) begin
            w_state_nxt = ST_EMPTY;
          end else begin
            w_state_nxt = ST_BUSY;
          end
        end
        ST_FULL: begin
          if (w_out_fire) begin
            w_state_nxt = ST_BUSY;
            w_main_sel  = SEL_SKID;
          end else begin
            w_state_nxt = ST_FULL;
          end
        end
        default: begin
          w_state_nxt = ST_EMPTY;
        end
      endcase
    end
  end

  // Handshake flags are taken from the next state so they are valid right after the edge.
  always_comb begin
    case (w_main_sel)
      SEL_IN:   w_main_nxt = in_data;
      SEL_SKID: w_main_nxt = r_skid;
      SEL_ZERO: w_main_nxt = {N{1'b0}};
      default:  w_main_nxt = r_main;
    endcase
    if (clear) begin
      w_skid_nxt = {N{1'b0}};
    end else if (w_skid_load) begin
      w_skid_nxt = in_data;
    end else begin
      w_skid_nxt = r_skid;
    end
    w_out_valid_nxt = state_has_beat(w_state_nxt);
    w_in_ready_nxt  = (w_state_nxt != ST_FULL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_main      <= {N{1'b0}};
      r_skid      <= {N{1'b0}};
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b0;
    end else begin
      r_main      <= w_main_nxt;
      r_skid      <= w_skid_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_in_ready  <= w_in_ready_nxt;
    end
  end

`ifdef SKID_REGISTER_STATS_EN
  logic [CNT_W-1:0] r_beat_count;

  assign beat_count = r_beat_count;

  // A beat popped during clear is not counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_beat_count <= {CNT_W{1'b0}};
    end else if (clear) begin
      r_beat_count <= {CNT_W{1'b0}};
    end else if (w_out_fire && (r_beat_count != {CNT_W{1'b1}})) begin
      r_beat_count <= r_beat_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_beat_count <= r_beat_count;
    end
  end
`endif

endmodule

// File: tb/tb_skid_register.sv
// Bench for skid_register: a two-deep FIFO queue model predicts every output.
// Build with SKID_REGISTER_STATS_EN defined to also exercise beat_count.
module tb_skid_register;

  localparam int N     = 32;
  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic         clk = 1'b0;
  logic         reset;
  logic         clear;
  logic [N-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
`ifdef SKID_REGISTER_STATS_EN
  logic [CNT_W-1:0] beat_count;
`endif

  skid_register #(.N(N), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef SKID_REGISTER_STATS_EN
    ,
    .beat_count(beat_count)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference: beats held in a queue of capacity two; ready reflects room after the edge.
  logic [N-1:0] m_q[$];
  bit           m_ready = 1'b0;
  int           m_cnt   = 0;

  // Drive one cycle's inputs (called just after a falling edge) and advance the model.
  task automatic cycle(input logic iv, input logic [N-1:0] d, input logic ordy,
                       input logic clr, input logic rst);
    bit inf;
    bit outf;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    clear     = clr;
    reset     = rst;
    inf  = iv && m_ready;
    outf = (m_q.size() != 0) && ordy;
    @(posedge clk);
    if (rst) begin
      m_q.delete();
      m_ready = 1'b0;
      m_cnt   = 0;
    end else if (clr) begin
      m_q.delete();
      m_ready = 1'b1;
      m_cnt   = 0;
    end else begin
      if (outf) begin
        void'(m_q.pop_front());
        if (m_cnt < CNT_MAX) m_cnt++;
      end
      if (inf) m_q.push_back(d);
      m_ready = (m_q.size() < 2);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_data !== '0) begin
        bad++;
        $display("FAIL reset_hold: valid=%b ready=%b data=%h, expected 0 0 0", out_valid, in_ready, out_data);
      end
    end
    reset = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_startup_ready: got %b expected 0", in_ready);
    end
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0) begin
      bad++;
      $display("FAIL reset_release: ready=%b valid=%b data=%h, expected 1 0 0", in_ready, out_valid, out_data);
    end
  endtask

  task automatic test_stream();
    for (int i = 1; i <= 10; i++) begin
      cycle(1'b1, N'(i), 1'b1, 1'b0, 1'b0);
      total++;
      if (out_valid !== 1'b1 || out_data !== N'(i)) begin
        bad++;
        $display("FAIL stream_data: valid=%b data=%h, expected 1 %h", out_valid, out_data, N'(i));
      end
      total++;
      if (in_ready !== 1'b1) begin
        bad++;
        $display("FAIL stream_ready: got %b expected 1", in_ready);
      end
    end
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL stream_drain: valid=%b ready=%b, expected 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_full_pop();
    cycle(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'hA) begin
      bad++;
      $display("FAIL full_state: ready=%b valid=%b data=%h, expected 0 1 a", in_ready, out_valid, out_data);
    end
    cycle(1'b1, 32'hE, 1'b0, 1'b0, 1'b0);
    total++;
    if (in_ready !== 1'b0 || out_data !== 32'hA) begin
      bad++;
      $display("FAIL full_hold: ready=%b data=%h, expected 0 a", in_ready, out_data);
    end
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    total++;
    if (out_valid !== 1'b1 || out_data !== 32'hB || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL full_pop1: valid=%b data=%h ready=%b, expected 1 b 1", out_valid, out_data, in_ready);
    end
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL full_pop2: valid=%b ready=%b, expected 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_clear();
    cycle(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'hC, 1'b0, 1'b1, 1'b0);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0) begin
      bad++;
      $display("FAIL clear_flush: valid=%b ready=%b data=%h, expected 0 1 0", out_valid, in_ready, out_data);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL clear_no_ghost: valid=%b data=%h, expected valid 0", out_valid, out_data);
      end
    end
    cycle(1'b1, 32'h5, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h6, 1'b0, 1'b1, 1'b1);
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_beats_clear: ready=%b valid=%b, expected 0 0", in_ready, out_valid);
    end
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_clear_release: ready=%b valid=%b, expected 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] seq     = 32'h100;
    logic [N-1:0] exp_out = 32'h100;
    logic [N-1:0] prev_data;
    bit           stalled;
    bit           iv;
    bit           ordy;
    bit           rdy_before;
    for (int c = 0; c < 10000; c++) begin
      iv   = bit'($urandom_range(0, 1));
      ordy = bit'($urandom_range(0, 1));
      if (out_valid === 1'b1 && ordy) begin
        total++;
        if (out_data !== exp_out) begin
          bad++;
          $display("FAIL rand_order: got %h expected %h at cycle %0d", out_data, exp_out, c);
        end
        exp_out++;
      end
      stalled    = (out_valid === 1'b1) && !ordy;
      prev_data  = out_data;
      rdy_before = m_ready;
      cycle(iv, seq, ordy, 1'b0, 1'b0);
      if (iv && rdy_before) seq++;
      total++;
      if (out_valid !== (m_q.size() != 0) || in_ready !== m_ready) begin
        bad++;
        $display("FAIL rand_flags: valid=%b ready=%b, expected %b %b at cycle %0d",
                 out_valid, in_ready, (m_q.size() != 0), m_ready, c);
      end
      if (m_q.size() != 0) begin
        total++;
        if (out_data !== m_q[0]) begin
          bad++;
          $display("FAIL rand_data: got %h expected %h at cycle %0d", out_data, m_q[0], c);
        end
      end
      if (stalled) begin
        total++;
        if (out_valid !== 1'b1 || out_data !== prev_data) begin
          bad++;
          $display("FAIL rand_stall: valid=%b data=%h, expected 1 %h at cycle %0d", out_valid, out_data, prev_data, c);
        end
      end
`ifdef SKID_REGISTER_STATS_EN
      total++;
      if (beat_count !== CNT_W'(m_cnt)) begin
        bad++;
        $display("FAIL rand_count: got %0d expected %0d at cycle %0d", beat_count, m_cnt, c);
      end
`endif
    end
  endtask

`ifdef SKID_REGISTER_STATS_EN
  task automatic test_stats();
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    total++;
    if (beat_count !== '0) begin
      bad++;
      $display("FAIL stats_reset: got %0d expected 0", beat_count);
    end
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 20; i++) cycle(1'b1, N'(i), 1'b1, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    total++;
    if (beat_count !== 4'd15 || m_cnt != 15) begin
      bad++;
      $display("FAIL stats_saturate: got %0d expected 15", beat_count);
    end
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
    total++;
    if (beat_count !== '0) begin
      bad++;
      $display("FAIL stats_clear: got %0d expected 0", beat_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_full_pop();
    test_clear();
    test_random();
`ifdef SKID_REGISTER_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
